ntt_pointwise_ctrl: RTL and testbench
=====================================

NTT_POINTWISE_CTRL -- requirements
Module: ntt_pointwise_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, coefficient count per polynomial (power of two, >=4).
REQ-002 SHALL have parameter WIDTH, default 32, coefficient bit width.
REQ-003 SHALL have parameter Q, default 3329, modulus.
REQ-004 SHALL have parameter REDUCTION_TYPE, default 0, passed to the multiplier: 0=SIMPLE, 1=BARRETT, 2=MONTGOMERY.
REQ-005 SHALL have localparam ADDR_W = $clog2(N).
REQ-006 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  input  1  request to process one polynomial pair.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the final write.
REQ-011 SHALL have port rd_en  output  1  read strobe to the A and B memories.
REQ-012 SHALL have port rd_addr  output  ADDR_W  read address shared by A and B.
REQ-013 SHALL have ports a_rdata, b_rdata  input  WIDTH each  memory data, valid one cycle after rd_en.
REQ-014 SHALL have port wr_en  output  1  write strobe to the C memory.
REQ-015 SHALL have port wr_addr  output  ADDR_W  C write address.
REQ-016 SHALL have port wr_data  output  WIDTH  (a_rdata*b_rdata) mod Q.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 SHALL move IDLE->RUN on the edge where start=1; this edge is cycle 0.
REQ-019 SHALL ignore start in RUN, DRAIN and DONE; there is no queuing.
REQ-020 SHALL, in RUN, drive rd_en=1 with rd_addr=0..N-1 on cycles 1..N, incrementing by one per cycle; all outputs are registered.
REQ-021 SHALL move RUN->DRAIN after issuing rd_addr=N-1, with rd_en=0 in DRAIN.
REQ-022 SHALL compute wr_data through one registered stage: rd_en on cycle t gives wr_en=1, wr_addr=rd_addr(t), wr_data on cycle t+2.
REQ-023 SHALL therefore assert wr_en on cycles 3..N+2, in ascending address order with no gaps.
REQ-024 SHALL move DRAIN->DONE after the final write and pulse done=1 on cycle N+3, then return to IDLE.
REQ-025 SHALL accept a start in the cycle after done (in IDLE) with no dead cycle.
REQ-026 SHALL hold busy=1 on cycles 1..N+2 and 0 otherwise.
REQ-027 SHALL use a read-address counter of exactly ADDR_W bits; the wrap from N-1 to 0 must never be issued.
REQ-028 SHALL give wr_data fully reduced, in the range 0..Q-1, for inputs in the range 0..Q-1.
REQ-029 SHALL leave behaviour for inputs >=Q unspecified, with no X-propagation into control.
REQ-030 SHALL keep wr_addr and wr_data at their last values while wr_en=0.

Reset
REQ-031 SHALL, with rst_n=0 at a rising edge, force state IDLE and busy, done, rd_en, wr_en = 0; rd_addr, wr_addr and wr_data go to 0.
REQ-032 SHALL, on reset mid-operation, abort the job with no further writes or done pulse; a fresh start afterwards begins at address 0.
REQ-033 SHALL let reset take priority over a simultaneous start.

Structure
REQ-034 SHALL take the FSM state enum and the reduction-type constants (SIMPLE/BARRETT/MONTGOMERY) from shared package ntt_pkg.
REQ-035 SHALL instantiate exactly one existing mod_mult (WIDTH, Q, REDUCTION_TYPE), time-shared across all N coefficients.
REQ-036 SHALL keep the pipeline valid/address shift registers local to this module, with no other sub-modules.

Verification (N=4, Q=3329, REDUCTION_TYPE 0, 1 and 2; behavioural 1-cycle-latency RAMs)
REQ-037 SHALL cover: A={1,2,3,4}, B={2,2,2,2}, start on cycle 0 -> C={2,4,6,8}; wr_en on cycles 3-6; done only on cycle 7.
REQ-038 SHALL cover: A[i]=B[i]=3328 -> every C[i]=1; A[i]=0 -> C[i]=0.
REQ-039 SHALL cover: start held high for 10 cycles -> exactly one job, one done pulse, busy on cycles 1-6.
REQ-040 SHALL cover: rst_n=0 on cycle 4 -> no wr_en or done afterwards; outputs 0 next cycle; re-start -> rd_addr begins at 0 and gives a correct C.
REQ-041 SHALL cover: start in the cycle after done -> second job on cycles 1..7 relative to it; both C results correct.
REQ-042 SHALL cover: start and rst_n=0 in the same cycle -> stays IDLE, busy=0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT datapath blocks: controller state encoding,
// reduction-type selectors and elaboration-time constant helpers for mod_mult.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_e;

  localparam int unsigned RED_SIMPLE     = 0;
  localparam int unsigned RED_BARRETT    = 1;
  localparam int unsigned RED_MONTGOMERY = 2;

  // Barrett multiplier floor(2^k / q); k must stay below 64.
  function automatic longint unsigned barrett_m(input longint unsigned q,
                                                input int unsigned k);
    return (64'd1 << k) / q;
  endfunction

  // -q^-1 mod 2^rb by Newton iteration (q odd; x0 = q is exact to 3 bits).
  function automatic longint unsigned mont_qinv_neg(input longint unsigned q,
                                                    input int unsigned rb);
    longint unsigned x;
    x = q;
    for (int i = 0; i < 5; i++) begin
      x = x * (64'd2 - q * x);
    end
    return (64'd0 - x) & ((64'd1 << rb) - 64'd1);
  endfunction

  // R^2 mod q with R = 2^rb, used to leave the Montgomery domain in one step.
  function automatic longint unsigned r2_mod(input longint unsigned q,
                                             input int unsigned rb);
    return (64'd1 << (2 * rb)) % q;
  endfunction

endpackage

// File: rtl/mod_mult.sv
// Combinational modular multiplier: prod_c = (a * b) mod Q.
// Ports: a, b (WIDTH operands, expected < Q); prod_c (WIDTH result, 0..Q-1).
// REDUCTION_TYPE selects plain modulo, Barrett, or Montgomery reduction.
module mod_mult
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned Q              = 3329,
  parameter int unsigned REDUCTION_TYPE = RED_SIMPLE
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned QB = $clog2(Q);
  localparam int unsigned K  = 2 * QB;
  localparam int unsigned EW = PW + K + 1;

  localparam logic [EW-1:0] QE    = EW'(Q);
  localparam logic [EW-1:0] BM    = EW'(barrett_m(64'(Q), K));
  localparam logic [EW-1:0] QINV  = EW'(mont_qinv_neg(64'(Q), QB));
  localparam logic [EW-1:0] R2    = EW'(r2_mod(64'(Q), QB));
  localparam logic [EW-1:0] RMASK = (EW'(1) << QB) - EW'(1);

  // Barrett estimate undershoots by at most two multiples of Q.
  function automatic logic [EW-1:0] barrett(input logic [EW-1:0] p);
    logic [EW-1:0] qh;
    logic [EW-1:0] u;
    qh = (p * BM) >> K;
    u  = p - qh * QE;
    if (u >= QE) u = u - QE;
    if (u >= QE) u = u - QE;
    return u;
  endfunction

  // Montgomery REDC: t * R^-1 mod Q for t < Q*R.
  function automatic logic [EW-1:0] redc(input logic [EW-1:0] t);
    logic [EW-1:0] m;
    logic [EW-1:0] u;
    m = ((t & RMASK) * QINV) & RMASK;
    u = (t + m * QE) >> QB;
    if (u >= QE) u = u - QE;
    return u;
  endfunction

  logic [EW-1:0] pe;
  logic [EW-1:0] res;

  // Operands widened before multiply so the full product is kept.
  always_comb begin
    pe  = EW'(a) * EW'(b);
    res = '0;
    case (REDUCTION_TYPE)
      RED_BARRETT:    res = barrett(pe);
      RED_MONTGOMERY: res = redc(redc(pe) * R2);
      default:        res = pe % QE;
    endcase
    prod_c = WIDTH'(res);
  end

endmodule

// File: rtl/ntt_pointwise_ctrl.sv
// Pointwise polynomial multiply controller: streams N coefficient pairs from
// the A/B memories through one shared mod_mult and writes C[i] = A[i]*B[i] mod Q.
// Ports: clk, rst_n (sync, active-low); start (request); busy, done (status);
// rd_en/rd_addr (A/B read, data one cycle later on a_rdata/b_rdata);
// wr_en/wr_addr/wr_data (C write). All outputs registered.
module ntt_pointwise_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned N              = 256,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned Q              = 3329,
  parameter int unsigned REDUCTION_TYPE = RED_SIMPLE,
  localparam int unsigned ADDR_W       = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  a_rdata,
  input  logic [WIDTH-1:0]  b_rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  ntt_state_e        state;
  logic [ADDR_W-1:0] cnt;
  logic              start_q;
  logic              p_vld;
  logic [ADDR_W-1:0] p_addr;
  logic [WIDTH-1:0]  prod_c;

  mod_mult #(
    .WIDTH         (WIDTH),
    .Q             (Q),
    .REDUCTION_TYPE(REDUCTION_TYPE)
  ) u_mod_mult (
    .a     (a_rdata),
    .b     (b_rdata),
    .prod_c(prod_c)
  );

  // Controller FSM plus read-to-write pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
      p_vld   <= 1'b0;
      p_addr  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      start_q <= start;
      done    <= 1'b0;

      // Stage 1 aligns with RAM read data; stage 2 registers the product.
      p_vld  <= rd_en;
      p_addr <= rd_addr;
      wr_en  <= p_vld;
      if (p_vld) begin
        wr_addr <= p_addr;
        wr_data <= prod_c;
      end

      case (state)
        // Only a rising start launches a job, so a held start runs once.
        ST_IDLE: begin
          if (start && !start_q) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        // Counter stops at N-1 so the wrap back to 0 is never issued.
        ST_RUN: begin
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= cnt;
          if (cnt == ADDR_W'(N - 1)) begin
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        // Last read is in flight once rd_en has dropped with stage 1 valid.
        ST_DRAIN: begin
          rd_en <= 1'b0;
          if (!rd_en && p_vld) begin
            state <= ST_DONE;
          end
        end
        // Final write is on the bus this cycle; done follows it.
        ST_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_pointwise_ctrl.sv
// Bench for ntt_pointwise_ctrl: three instances (SIMPLE, BARRETT, MONTGOMERY)
// share stimulus and are compared every cycle against a job-timeline model.
module tb_ntt_pointwise_ctrl;
  import ntt_pkg::*;

  localparam int unsigned N      = 4;
  localparam int unsigned W      = 32;
  localparam int unsigned Q      = 3329;
  localparam int unsigned ADDR_W = $clog2(N);
  localparam int unsigned NI     = 3;

  logic clk;
  logic rst_n;
  logic start;

  logic [NI-1:0]     busy;
  logic [NI-1:0]     done;
  logic [NI-1:0]     rd_en;
  logic [NI-1:0]     wr_en;
  logic [ADDR_W-1:0] rd_addr [NI];
  logic [ADDR_W-1:0] wr_addr [NI];
  logic [W-1:0]      wr_data [NI];
  logic [W-1:0]      a_rd    [NI];
  logic [W-1:0]      b_rd    [NI];

  logic [W-1:0] mem_a [N];
  logic [W-1:0] mem_b [N];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ntt_pointwise_ctrl #(
      .N(N), .WIDTH(W), .Q(Q), .REDUCTION_TYPE(g)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .busy   (busy[g]),
      .done   (done[g]),
      .rd_en  (rd_en[g]),
      .rd_addr(rd_addr[g]),
      .a_rdata(a_rd[g]),
      .b_rdata(b_rd[g]),
      .wr_en  (wr_en[g]),
      .wr_addr(wr_addr[g]),
      .wr_data(wr_data[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency read memories, one read port per instance.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rd_en[k]) begin
        a_rd[k] <= mem_a[rd_addr[k]];
        b_rd[k] <= mem_b[rd_addr[k]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference timeline: a job accepted on edge j reads on j+1..j+N, writes on
  // j+3..j+N+2, is busy on j+1..j+N+2 and pulses done on j+N+3.
  int          cyc = 0;
  bit          chk_en = 0;
  bit          have_job = 0;
  bit          prev_start = 0;
  int          job = 0;
  int          rel;
  logic [63:0] exp_c [N];
  bit          e_busy, e_done, e_rd_en, e_wr_en;
  logic [63:0] e_rd_addr, e_wa, e_wd;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk_en     = 1;
      have_job   = 0;
      prev_start = 0;
      e_busy     = 0;
      e_done     = 0;
      e_rd_en    = 0;
      e_wr_en    = 0;
      e_rd_addr  = 0;
      e_wa       = 0;
      e_wd       = 0;
    end else begin
      if (start && !prev_start && (!have_job || (cyc - job) >= int'(N) + 4)) begin
        have_job = 1;
        job      = cyc;
        for (int i = 0; i < int'(N); i++)
          exp_c[i] = (64'(mem_a[i]) * 64'(mem_b[i])) % 64'(Q);
      end
      prev_start = start;
      rel = have_job ? (cyc - job) : 100000;
      e_busy  = (rel >= 1) && (rel <= int'(N) + 2);
      e_done  = (rel == int'(N) + 3);
      e_rd_en = (rel >= 1) && (rel <= int'(N));
      e_wr_en = (rel >= 3) && (rel <= int'(N) + 2);
      if (e_rd_en) e_rd_addr = 64'(rel - 1);
      if (e_wr_en) begin
        e_wa = 64'(rel - 3);
        e_wd = exp_c[rel - 3];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("busy[rt%0d]@%0d", k, cyc), 64'(busy[k]), 64'(e_busy));
        check($sformatf("done[rt%0d]@%0d", k, cyc), 64'(done[k]), 64'(e_done));
        check($sformatf("rd_en[rt%0d]@%0d", k, cyc), 64'(rd_en[k]), 64'(e_rd_en));
        check($sformatf("rd_addr[rt%0d]@%0d", k, cyc), 64'(rd_addr[k]), e_rd_addr);
        check($sformatf("wr_en[rt%0d]@%0d", k, cyc), 64'(wr_en[k]), 64'(e_wr_en));
        check($sformatf("wr_addr[rt%0d]@%0d", k, cyc), 64'(wr_addr[k]), e_wa);
        check($sformatf("wr_data[rt%0d]@%0d", k, cyc), 64'(wr_data[k]), e_wd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i] = W'($urandom_range(Q - 1, 0));
      mem_b[i] = W'($urandom_range(Q - 1, 0));
    end
  endtask

  task automatic run_job();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(N + 5);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    tick(3);
    rst_n = 1'b1;

    // Basic job: C = {2,4,6,8}.
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i] = W'(i + 1);
      mem_b[i] = W'(2);
    end
    run_job();

    // Largest residues: (Q-1)^2 mod Q = 1.
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i] = W'(Q - 1);
      mem_b[i] = W'(Q - 1);
    end
    run_job();

    // Zero operand.
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i] = '0;
      mem_b[i] = W'($urandom_range(Q - 1, 0));
    end
    run_job();

    // Start held for ten cycles launches a single job.
    fill_random();
    start = 1'b1;
    tick(10);
    start = 1'b0;
    tick(N + 4);

    // Reset lands on cycle 4 of a job, then a clean restart.
    fill_random();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    fill_random();
    run_job();

    // Back-to-back: second start sampled the cycle after done.
    fill_random();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    fill_random();
    run_job();

    // Reset and start on the same edge: nothing launches.
    rst_n = 1'b0;
    start = 1'b1;
    tick(1);
    rst_n = 1'b1;
    start = 1'b0;
    tick(5);

    // Random jobs with idle gaps of 0..3 cycles after done.
    for (int j = 0; j < 8; j++) begin
      fill_random();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(7 + int'($urandom_range(3, 0)));
    end
    tick(N + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
